// File: rtl/tlb_fetch_queue.sv
// rtl/tlb_fetch_queue.sv - PC-driven TLB fetch front-end with prefetch FIFO and redirect flush
module tlb_fetch_queue #(
  parameter int AW       = 6,
  parameter int DW       = 16,
  parameter int DEPTH    = 4,
  parameter int PROG_LEN = 38
) (
  input  logic                     Clock,
  input  logic                     Resetn,
  input  logic                     Run,
  input  logic                     Redirect,
  input  logic [AW-1:0]            RedirectAddr,
  output logic [AW-1:0]            TlbAddr,
  input  logic [DW-1:0]            TlbData,
  output logic                     InstrValid,
  output logic [DW-1:0]            Instr,
  output logic [AW-1:0]            InstrAddr,
  input  logic                     InstrReady,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Done
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CW   = PTRW + 1;
  localparam int EW   = AW + DW;
  // PC carries one extra bit so it can sit at PROG_LEN == 2^AW without wrapping
  localparam logic [AW:0]   PROG_END = (AW + 1)'(PROG_LEN);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW:0]     pc_q, pc_d;
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [EW-1:0]   mem_d [DEPTH];

  logic pop;
  logic push;

  assign TlbAddr    = pc_q[AW-1:0];
  assign InstrValid = (count_q != '0);
  assign Instr      = mem_q[rd_ptr_q][DW-1:0];
  assign InstrAddr  = mem_q[rd_ptr_q][EW-1:DW];
  assign Count      = count_q;
  assign Done       = (pc_q >= PROG_END) && (count_q == '0);

  // Next-state: redirect flushes and reloads PC; otherwise push/pop the FIFO
  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end

    pop  = InstrValid && InstrReady;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    push = Run && !Redirect && (pc_q < PROG_END) && ((count_q < FULL_CNT) || pop);

    if (Redirect) begin
      // Any same-cycle pop is considered delivered; the flush discards the rest
      pc_d     = {1'b0, RedirectAddr};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {pc_q[AW-1:0], TlbData};
        wr_ptr_d        = wr_ptr_q + PTRW'(1);
        pc_d            = pc_q + (AW + 1)'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTRW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // State registers; reset clears storage so the stale head reads as zero
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pc_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: doc/tlb_fetch_queue.md
# tlb_fetch_queue

Instruction fetch front-end that sits directly upstream of the TLB. It owns the program counter and drives the 6-bit virtual address into the TLB, then captures the returned 16-bit word in the same cycle. Captured words go into a small prefetch FIFO, and the processor control unit drains that FIFO through a valid/ready handshake. A redirect input reloads the PC and flushes the FIFO to support taken MVNZ / PC writes.

## Interface
- AW, 6, virtual address width (matches TLB addr)
- DW, 16, instruction word width (matches TLB out)
- DEPTH, 4, FIFO entries; power of two, >= 2
- PROG_LEN, 38, number of valid program words; 1 <= PROG_LEN <= 2^AW
- Clock  in  1  single clock; all state updates on rising edge
- Resetn  in  1  asynchronous, active-low reset
- Run  in  1  fetch enable; when low, no new words are fetched (pops still allowed)
- Redirect  in  1  load PC from RedirectAddr and flush FIFO
- RedirectAddr  in  AW  new fetch address
- TlbAddr  out  AW  address to TLB, equal to PC[AW-1:0]
- TlbData  in  DW  combinational TLB response for TlbAddr
- InstrValid  out  1  FIFO head valid
- Instr  out  DW  FIFO head word
- InstrAddr  out  AW  address the head word was fetched from
- InstrReady  in  1  consumer accepts head this cycle
- Count  out  $clog2(DEPTH)+1  current occupancy
- Done  out  1  program exhausted and FIFO empty

## Operation
- State: PC (AW+1 bits, so it can hold PROG_LEN without wrapping), FIFO storage of {addr, word} × DEPTH, read/write pointers, occupancy counter.
- pop = InstrValid && InstrReady.
- push = Run && !Redirect && (PC < PROG_LEN) && (Count < DEPTH || pop).
- On push: write {PC[AW-1:0], TlbData} at the write pointer, advance the write pointer, and set PC <= PC+1.
- On pop: advance the read pointer.
- Count update:
  - +1 on push only
  - −1 on pop only
  - unchanged when both or neither occur
- Pointers wrap modulo DEPTH.
- Full (Count==DEPTH) with a simultaneous pop: the push is accepted, and Count stays at DEPTH.
- Empty: InstrValid=0. Instr and InstrAddr show the stale head entry and carry no meaning.
- Redirect (highest priority):
  - On that edge, PC <= {1'b0, RedirectAddr}, both pointers are set to 0, and Count is set to 0.
  - No push occurs that cycle.
  - A pop asserted in the same cycle counts as completed for the consumer, but the FIFO is flushed anyway.
- RedirectAddr >= PROG_LEN: PC is loaded, no fetch follows, and Done asserts on the next cycle.
- When PC reaches PROG_LEN, fetching stops. Done = (PC >= PROG_LEN) && (Count == 0), combinational from registers.
- TLB returns 0 on a miss. This block does not treat 0 as a miss (0 is legal data, e.g. an immediate #0), so range is controlled by PROG_LEN alone.
- Run low: PC holds, and the FIFO keeps draining normally.

## Timing
- Reset (async assert, applies immediately):
  - PC=0, pointers=0, Count=0, storage cleared to 0
  - InstrValid=0, Instr=0, InstrAddr=0, TlbAddr=0, Done=0
- Fetch latency: with Run=1, the word at address A is pushed on the edge where PC==A. InstrValid rises the cycle after that edge when the FIFO was empty (one-cycle address-to-head latency).
- Throughput: one word per cycle, sustained while the consumer pops every cycle.
- Handshake: InstrValid is never deasserted without a pop or Redirect. Instr and InstrAddr are stable while InstrValid=1 and InstrReady=0.
- Redirect: InstrValid=0 the cycle after the Redirect edge. The word at RedirectAddr appears at the head one cycle later (when Run=1).
- Resetn deasserted mid-fetch: no partial write. The FIFO restarts empty and PC restarts at 0.

## Test plan
- Reset release, Run=1, InstrReady=1, TLB model returns 0x4000@0, 0x0002@1, 0x4200@2 -> the head shows (0,0x4000), then (1,0x0002), then (2,0x4200) on consecutive cycles; InstrValid first high 1 cycle after the first edge.
- InstrReady=0 with Run=1 -> exactly 4 pushes; Count=4; TlbAddr holds at 4. Assert InstrReady for 1 cycle -> one pop plus one push, Count stays 4, PC=5.
- Redirect with RedirectAddr=20 while Count=3 and InstrReady=1 -> next cycle Count=0, InstrValid=0, PC=20; the following cycle the head is addr 20.
- Run through the end with PROG_LEN=38 -> the last word pushed is addr 37; PC sticks at 38; Done=1 the cycle after the final pop; TlbAddr never requests beyond 38.
- Redirect to 40 (>= PROG_LEN) -> no pushes; Done=1 the cycle after the redirect edge.
- Assert Resetn=0 asynchronously mid-stream with Count=2 -> outputs go to reset values immediately, without a clock edge; after release, fetching restarts at addr 0.
